// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for the programmable clock divider.
//   sel_e    - ratio encodings; value k selects divide-by-2^(k+1)
//   SEL_MAX  - largest legal ratio encoding
//   state_e  - controller FSM states
//   sel_legal() - true when a requested encoding is in range
package clk_div_pkg;

  typedef enum logic [2:0] {
    SEL_DIV2  = 3'd0,
    SEL_DIV4  = 3'd1,
    SEL_DIV8  = 3'd2,
    SEL_DIV16 = 3'd3,
    SEL_DIV32 = 3'd4
  } sel_e;

  localparam logic [2:0] SEL_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  function automatic logic sel_legal(input logic [2:0] s);
    return (s <= SEL_MAX);
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter: divide counter, divided-clock and boundary/tick generation.
// Ports:
//   clk, rst      - system clock, synchronous active-low reset
//   clr           - force counter and outputs to zero on the next edge
//   run           - advance the counter by one per cycle
//   sel [2:0]     - active ratio k (divide-by-2^(k+1))
//   clk_out       - registered divided clock, low for 2^k cycles then high for 2^k
//   tick          - registered pulse on the last cycle of each clk_out period
//   boundary      - combinational: this cycle is the last of a clk_out period
module clk_div_counter #(
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       run,
  input  logic [2:0] sel,
  output logic       clk_out,
  output logic       tick,
  output logic       boundary
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_mask;   // bits [k:0] set: period boundary mask
  logic [CNT_W-1:0] w_hbit;   // bit k set: selects the half-period bit
  logic             r_clk_out;
  logic             r_tick;

  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    w_mask    = '0;
    w_hbit    = '0;
    for (int i = 0; i < CNT_W; i++) begin
      w_mask[i] = (i <= int'(sel));
      w_hbit[i] = (i == int'(sel));
    end
  end

  assign boundary = run && ((r_cnt & w_mask) == w_mask);

  // clk_out and tick are computed from the next count so that, once
  // registered, they line up with the count value they describe.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (run) begin
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= |(w_cnt_nxt & w_hbit);
      r_tick    <= ((w_cnt_nxt & w_mask) == w_mask);
    end else begin
      r_tick    <= 1'b0;
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with glitch-free ratio switching.
// Ports:
//   clk, rst     - system clock, synchronous active-low reset
//   en           - run request; dropping it stops at the next period boundary
//   req, sel_in  - ratio-change request and requested ratio k (0..4 legal)
//   ready        - request accepted on a cycle with req && ready
//   ack          - pulse on the cycle a new ratio takes effect
//   err          - pulse after an accepted request with an illegal ratio
//   cur_sel      - ratio currently active
//   running      - high in RUN or SWITCH
//   clk_out      - divided clock, 50% duty
//   tick         - pulse on the last cycle of each clk_out period
// Handshake: a request transfers on any clock edge where req && ready are both
// high; ready is low only while a switch is pending, so at most one request is
// ever held and req is ignored until the switch completes.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int         CNT_W   = 5,
  parameter logic [2:0] RST_SEL = SEL_DIV2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req,
  input  logic [2:0] sel_in,
  output logic       ready,
  output logic       ack,
  output logic       err,
  output logic [2:0] cur_sel,
  output logic       running,
  output logic       clk_out,
  output logic       tick
);

  state_e     r_state;
  logic [2:0] r_cur_sel;
  logic [2:0] r_new_sel;
  logic       r_ack;
  logic       r_err;
  logic       r_running;

  logic w_ready;
  logic w_acc;
  logic w_legal;
  logic w_go_switch;
  logic w_stop;
  logic w_sw_done;
  logic w_clr;
  logic w_run;
  logic w_boundary;

  assign w_ready     = (r_state != ST_SWITCH);
  assign w_acc       = req && w_ready;
  assign w_legal     = sel_legal(sel_in);
  // A legal request in RUN wins over a stop on the same boundary; the stop
  // then happens after the switch completes.
  assign w_go_switch = (r_state == ST_RUN) && w_acc && w_legal;
  assign w_stop      = (r_state == ST_RUN) && w_boundary && !en && !w_go_switch;
  assign w_sw_done   = (r_state == ST_SWITCH) && w_boundary;
  assign w_clr       = (r_state == ST_IDLE) || w_stop || w_sw_done;
  assign w_run       = (r_state != ST_IDLE);

  clk_div_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .run      (w_run),
    .sel      (r_cur_sel),
    .clk_out  (clk_out),
    .tick     (tick),
    .boundary (w_boundary)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cur_sel <= RST_SEL;
      r_new_sel <= RST_SEL;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= w_acc && !w_legal;
      case (r_state)
        ST_IDLE: begin
          // Counter is held clear here, so a new ratio applies immediately.
          if (w_acc && w_legal) begin
            r_cur_sel <= sel_in;
            r_new_sel <= sel_in;
            r_ack     <= 1'b1;
          end
          if (en) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_go_switch) begin
            r_new_sel <= sel_in;
            r_state   <= ST_SWITCH;
          end else if (w_stop) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        end
        ST_SWITCH: begin
          // Switch only at a period end of the old ratio: clk_out has just
          // finished a full high phase and restarts low, so no runt pulse.
          if (w_boundary) begin
            r_cur_sel <= r_new_sel;
            r_ack     <= 1'b1;
            if (en) begin
              r_state <= ST_RUN;
            end else begin
              r_state   <= ST_IDLE;
              r_running <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = w_ready || !rst;
  assign ack     = r_ack;
  assign err     = r_err;
  assign cur_sel = r_cur_sel;
  assign running = r_running;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for clk_div_ctrl.
// Observed vector layout: {ready, running, ack, err, clk_out, tick, cur_sel[2:0]}
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       req;
  logic [2:0] sel_in;
  logic       ready;
  logic       ack;
  logic       err;
  logic [2:0] cur_sel;
  logic       running;
  logic       clk_out;
  logic       tick;

  logic [8:0] w_obs;
  int         n_vec;
  int         n_err;

  assign w_obs = {ready, running, ack, err, clk_out, tick, cur_sel};

  clk_div_ctrl #(.CNT_W(5), .RST_SEL(3'd0)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .sel_in  (sel_in),
    .ready   (ready),
    .ack     (ack),
    .err     (err),
    .cur_sel (cur_sel),
    .running (running),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance one cycle; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    en     = 1'b0;
    req    = 1'b0;
    sel_in = 3'd0;
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [8:0] e;
    rst = 1'b0; en = 1'b1; req = 1'b1; sel_in = 3'd3;
    step();
    step();
    e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", w_obs, e);
    end
    rst = 1'b1; en = 1'b0; req = 1'b0;
    step();
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL reset_idle: got %b want %b", w_obs, e);
    end
  endtask

  task automatic test_default_div2();
    logic [8:0] e;
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      e = {1'b1, 1'b1, 1'b0, 1'b0, i[0], i[0], 3'd0};
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL div2 cyc %0d: got %b want %b", i, w_obs, e);
      end
      step();
    end
  endtask

  task automatic test_switch_4_to_32();
    logic [8:0] e;
    do_reset();
    en = 1'b1; req = 1'b1; sel_in = 3'd1;
    step();
    e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL idle_req_en: got %b want %b", w_obs, e);
    end
    req = 1'b0;
    step();
    e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL div4_cnt1: got %b want %b", w_obs, e);
    end
    req = 1'b1; sel_in = 3'd4;
    step();
    e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL sw_pending: got %b want %b", w_obs, e);
    end
    req = 1'b0;
    step();
    e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL sw_boundary: got %b want %b", w_obs, e);
    end
    step();
    e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL sw_ack: got %b want %b", w_obs, e);
    end
    for (int j = 1; j <= 40; j++) begin
      logic [5:0] jj;
      jj = 6'(j);
      step();
      e = {1'b1, 1'b1, 1'b0, 1'b0, jj[4], (jj[4:0] == 5'd31), 3'd4};
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL div32 cyc %0d: got %b want %b", j, w_obs, e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [8:0] e;
    do_reset();
    req = 1'b1; sel_in = 3'd7;
    step();
    e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL err_idle: got %b want %b", w_obs, e);
    end
    req = 1'b0; en = 1'b1;
    step();
    e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL err_run0: got %b want %b", w_obs, e);
    end
    req = 1'b1; sel_in = 3'd6;
    step();
    e = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL err_run: got %b want %b", w_obs, e);
    end
    req = 1'b0;
    for (int i = 2; i < 10; i++) begin
      logic [3:0] ii;
      ii = 4'(i);
      step();
      e = {1'b1, 1'b1, 1'b0, 1'b0, ii[0], ii[0], 3'd0};
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL err_after cyc %0d: got %b want %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_stop_div8();
    logic [8:0] e;
    do_reset();
    en = 1'b1; req = 1'b1; sel_in = 3'd2;
    step();
    e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL div8_start: got %b want %b", w_obs, e);
    end
    req = 1'b0;
    for (int i = 1; i < 8; i++) begin
      logic [3:0] ii;
      ii = 4'(i);
      step();
      e = {1'b1, 1'b1, 1'b0, 1'b0, ii[2], (ii[2:0] == 3'd7), 3'd2};
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL div8_stop cyc %0d: got %b want %b", i, w_obs, e);
      end
      if (i == 5) en = 1'b0;
    end
    e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    for (int i = 0; i < 7; i++) begin
      step();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL div8_idle cyc %0d: got %b want %b", i, w_obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    do_reset();
    en = 1'b1;
    step();
    step();
    // Request accepted on a div-2 boundary cycle.
    req = 1'b1; sel_in = 3'd1;
    step();
    e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL b2b_pending: got %b want %b", w_obs, e);
    end
    sel_in = 3'd2;
    step();
    e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL b2b_boundary: got %b want %b", w_obs, e);
    end
    step();
    e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL b2b_ack: got %b want %b", w_obs, e);
    end
    req = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      logic [3:0] jj;
      jj = 4'(j);
      step();
      e = {1'b1, 1'b1, 1'b0, 1'b0, jj[1], (jj[1:0] == 2'd3), 3'd1};
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL b2b_div4 cyc %0d: got %b want %b", j, w_obs, e);
      end
    end
  endtask

  task automatic test_reset_in_switch();
    logic [8:0] e;
    do_reset();
    en = 1'b1; req = 1'b1; sel_in = 3'd2;
    step();
    req = 1'b0;
    step();
    req = 1'b1; sel_in = 3'd4;
    step();
    req = 1'b0;
    step();
    e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL rsw_pending: got %b want %b", w_obs, e);
    end
    rst = 1'b0;
    #1;
    e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL rsw_ready_in_rst: got %b want %b", w_obs, e);
    end
    step();
    e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL rsw_reset: got %b want %b", w_obs, e);
    end
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL rsw_after cyc %0d: got %b want %b", i, w_obs, e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b0;
    en     = 1'b0;
    req    = 1'b0;
    sel_in = 3'd0;
    test_reset();
    test_default_div2();
    test_switch_4_to_32();
    test_illegal();
    test_stop_div8();
    test_back_to_back();
    test_reset_in_switch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL use the parameter CNT_W, default 5, as the width of the divide counter; the maximum ratio is 2^CNT_W.
REQ-002 The block SHALL use the parameter RST_SEL, default 3'd0 (divide-by-2), as the ratio applied at reset.
REQ-003 The clock and reset SHALL be decided as follows: reset rst, synchronous, active-low; clock clk.
REQ-004 Ports, as name / direction / width / meaning:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-low reset.
- en, in, 1, run request; 1 = divider running, 0 = stop at the next period boundary.
- req, in, 1, ratio-change request.
- sel_in, in, 3, requested ratio; value k selects divide-by-2^(k+1); k = 0..4 are legal.
- ready, out, 1, a request is accepted on a cycle where req && ready.
- ack, out, 1, one-cycle pulse on the cycle a new ratio takes effect.
- err, out, 1, one-cycle pulse marking an illegal sel_in.
- cur_sel, out, 3, ratio currently active.
- running, out, 1, high while in RUN or SWITCH.
- clk_out, out, 1, registered divided clock, 50% duty.
- tick, out, 1, one-cycle pulse on the last clk cycle of each clk_out period.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and SWITCH.
REQ-006 In IDLE, cnt SHALL hold 0 and clk_out and tick SHALL be 0; en=1 SHALL move the FSM to RUN on the next edge, with cnt counting from 0.
REQ-007 In RUN and SWITCH, cnt SHALL increment by 1 per cycle, mod 2^CNT_W.
REQ-008 With the active ratio k, clk_out SHALL be 0 for 2^k cycles and then 1 for 2^k cycles; the first rising edge SHALL occur 2^k cycles after RUN entry.
REQ-009 The period boundary SHALL be the cycle where cnt[k:0] is all ones; tick SHALL be 1 on exactly that cycle.
REQ-010 ready SHALL be 1 in IDLE and RUN and 0 in SWITCH.
REQ-011 A request accepted with sel_in > 4 SHALL pulse err on the next cycle, with no change to state, cur_sel or ack.
REQ-012 A legal request accepted in IDLE SHALL update cur_sel and pulse ack on the next cycle.
REQ-013 A legal request accepted in RUN SHALL store the new ratio and move the FSM to SWITCH.
REQ-014 A request accepted on a boundary cycle SHALL wait for the next boundary of the old ratio; the current boundary SHALL NOT count.
REQ-015 In SWITCH, on the boundary cycle, the next edge SHALL:
- load cur_sel with the new ratio;
- set cnt to 0;
- pulse ack.
REQ-016 The ratio switch SHALL NOT produce a clk_out pulse shorter than min(old, new) half-period.
REQ-017 When en=0 in RUN, the FSM SHALL continue to the next boundary and then enter IDLE, with cnt=0 and clk_out=0.
REQ-018 When en=0 in SWITCH, the pending switch SHALL complete and ack first; the FSM SHALL then enter IDLE instead of RUN.
REQ-019 When en=1 and a legal req occur in the same IDLE cycle, the next edge SHALL apply the ratio and enter RUN with the new ratio.
REQ-020 The block SHALL hold at most one pending request; req is ignored while ready=0.

Reset
REQ-021 On an edge with rst=0, the block SHALL set:
- the FSM to IDLE;
- cnt to 0;
- cur_sel to RST_SEL;
- the pending ratio to RST_SEL;
- clk_out, tick, ack, err and running to 0.
REQ-022 ready SHALL be 1 during and after reset.
REQ-023 A reset in the middle of a SWITCH SHALL discard the pending ratio and SHALL NOT produce an ack.
REQ-024 rst SHALL have priority over en and req.

Structure
REQ-025 The ratio encodings SEL_DIV2..SEL_DIV32, the constant SEL_MAX=4 and the FSM state enum SHALL be defined in the shared package clk_div_pkg.
REQ-026 The counter, clk_out generation and boundary/tick detection SHALL be one sub-module, clk_div_counter, with inputs clr, run and sel and outputs clk_out, tick and boundary; the FSM and handshake SHALL live in clk_div_ctrl.
REQ-027 Outputs ack, err, clk_out and tick SHALL be registered.

Verification
REQ-028 The bench SHALL cover:
- Reset, then en=1 with the default ratio: clk_out toggles every cycle (period 2); tick every 2nd cycle; running=1 one cycle after en.
- In RUN at divide-by-4, req with sel_in=4: ready=0 until the next div-4 boundary; on the following cycle ack=1 and cur_sel=4; clk_out then has period 32 with its first rise 16 cycles later.
- req with sel_in=6 in RUN: err=1 for one cycle; cur_sel and clk_out period unchanged; ack stays 0.
- In RUN at divide-by-8, en=0 mid-period: clk_out finishes its high phase; IDLE at the boundary; running=0; clk_out=0 thereafter.
- req with sel_in=2 while in SWITCH: ignored (ready=0); only the first request is applied and acked once.
- rst=0 asserted during SWITCH: cur_sel=RST_SEL, state IDLE, no ack pulse, ready=1.
